cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; the successor of the fixed 32-bit ripple-of-4-bit-CLA adder.
- Operand width, lookahead group size and pipeline depth are all parameters.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake on both sides.
- Sits between operand registers and the ALU result mux in the datapath.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of GROUP.
- GROUP, 4: bits per lookahead group, each with internal generate/propagate lookahead.
- STAGES, 2: pipeline register stages. NG = WIDTH/GROUP must be divisible by STAGES. Each stage resolves NG/STAGES groups.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in; used in add mode only
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum or difference
- co  out  1  carry-out; in subtract mode, 1 = no borrow
- ov  out  1  two's-complement signed overflow
- z  out  1  s == 0

Behaviour:
- **Arithmetic**
  - add: {co,s} = a + b + ci.
  - sub: {co,s} = a + ~b + 1; ci is ignored.
  - ov = (a[W-1] == b'[W-1]) && (s[W-1] != a[W-1]), where b' is b in add mode and ~b in sub mode.
  - z is computed from the final s.
- **Pipeline structure**
  - Stage k (k = 0..STAGES-1) computes groups k·NG/STAGES .. (k+1)·NG/STAGES-1, using the carry registered from stage k-1. Stage 0 uses ci, or 1 in sub mode.
  - Lower result bits already produced and upper operand bits not yet consumed are carried forward in the stage registers alongside the inter-stage carry.
- **Latency**
  - Exactly STAGES cycles from an accepted input to the matching out_valid, when there is no backpressure.
  - Throughput is one result per cycle.
- **Handshake**
  - advance = !out_valid || out_ready.
  - in_ready = advance, and it is combinational.
  - A transfer occurs when in_valid && in_ready.
  - When advance = 1, every stage shifts one place. A stage receiving no transfer is loaded as a bubble (valid bit 0).
  - When advance = 0, all stage registers, including data and valid bits, hold.
  - s, co, ov and z remain stable while out_valid && !out_ready.
  - Bubbles are not compressed.
- **Reset**
  - reset_n low clears all stage valid bits, out_valid, s, co, ov and z to 0, immediately and asynchronously.
  - Reset mid-operation discards all in-flight results; nothing is replayed.
  - in_ready = 1 as soon as reset_n deasserts.
- **Boundary conditions**
  - Full pipeline with out_ready = 0: in_ready = 0 and no input is lost.
  - A result draining while a new input enters in the same cycle is legal and occurs at full rate.
  - sub with b = 0 gives co = 1.
  - Wrap-around: the result is truncated to WIDTH bits, and the carry is reported only on co.
  - Elaboration fails via a generate error if WIDTH % GROUP != 0 or NG % STAGES != 0.

Test Plan (WIDTH=32, GROUP=4, STAGES=2 unless noted):
- a=0xFFFFFFFF, b=0, ci=1, add → two cycles later s=0, co=1, z=1, ov=0. The carry crosses the stage boundary.
- a=0x7FFFFFFF, b=1, ci=0, add → s=0x80000000, co=0, ov=1, z=0.
- sub, a=5, b=7 → s=0xFFFFFFFE, co=0, ov=0. Then sub, a=0x80000000, b=1 → s=0x7FFFFFFF, co=1, ov=1.
- Ten back-to-back random operands, out_ready=1 → ten results in order on consecutive cycles, matching the reference model. Then hold out_ready=0 for 3 cycles mid-stream → in_ready=0 after two accepts, outputs stable, no loss or duplication.
- Pulse reset_n low while two results are in flight → out_valid=0 immediately, outputs 0, no stale result after release.
- Rerun the random stream at WIDTH=64/GROUP=8/STAGES=4 and at WIDTH=16/GROUP=4/STAGES=1 → latency equals STAGES and all results match the model.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage resolves a slice of lookahead groups and passes its carry on.
module cla_addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov,
   output logic             z
);

   localparam int NG  = WIDTH / GROUP;
   localparam int GPS = NG / STAGES;
   localparam int SW  = GPS * GROUP;

   if (WIDTH % GROUP != 0) begin : g_err_w
      $error("WIDTH must be a multiple of GROUP");
   end
   if (NG % STAGES != 0) begin : g_err_s
      $error("WIDTH/GROUP must be divisible by STAGES");
   end

   // One lookahead group: every carry is a flat sum of products of g/p.
   function automatic logic [GROUP:0] cla_grp(
      input logic [GROUP-1:0] ga,
      input logic [GROUP-1:0] gb,
      input logic             cin
   );
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP:0]   c;
      logic             t;
      logic             pp;
      g    = ga & gb;
      p    = ga ^ gb;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         t  = 1'b0;
         pp = 1'b1;
         for (int j = i; j >= 0; j--) begin
            t  = t | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = t | (pp & cin);
      end
      return {c[GROUP], p ^ c[GROUP-1:0]};
   endfunction

   logic w_adv;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Operand bits still to be consumed shrink by SW per stage,
      // finished result bits grow by SW per stage.
      localparam int IW = WIDTH - k * SW;
      localparam int RW = (k + 1) * SW;

      logic [IW-1:0] w_oa;
      logic [IW-1:0] w_ob;
      logic          w_ic;
      logic          w_iv;
      logic [SW-1:0] w_sum;
      logic [GPS:0]  w_gc;
      logic [RW-1:0] w_res;
      logic [RW-1:0] r_s;
      logic          r_c;
      logic          r_v;

      if (k == 0) begin : g_src
         assign w_oa  = a;
         assign w_ob  = b ^ {WIDTH{sub}};
         assign w_ic  = sub | ci;
         assign w_iv  = in_valid;
         assign w_res = w_sum;
      end else begin : g_src
         assign w_oa  = g_st[k-1].g_op.r_a;
         assign w_ob  = g_st[k-1].g_op.r_b;
         assign w_ic  = g_st[k-1].r_c;
         assign w_iv  = g_st[k-1].r_v;
         assign w_res = {w_sum, g_st[k-1].r_s};
      end

      // Resolve this stage's groups, chaining group carries upward.
      always_comb begin
         w_gc    = '0;
         w_sum   = '0;
         w_gc[0] = w_ic;
         for (int gi = 0; gi < GPS; gi++) begin
            {w_gc[gi+1], w_sum[gi*GROUP +: GROUP]} =
               cla_grp(w_oa[gi*GROUP +: GROUP],
                       w_ob[gi*GROUP +: GROUP],
                       w_gc[gi]);
         end
      end

      // Stage register: shifts on advance, holds otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (w_adv) begin
            r_v <= w_iv;
            r_c <= w_gc[GPS];
            r_s <= w_res;
         end
      end

      if (k < STAGES - 1) begin : g_op
         logic [IW-SW-1:0] r_a;
         logic [IW-SW-1:0] r_b;

         // Carry the unconsumed upper operand bits forward.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_oa[IW-1:SW];
               r_b <= w_ob[IW-1:SW];
            end
         end
      end else begin : g_fl
         logic r_ov;
         logic r_z;

         // Flags from the top operand bits and the completed sum.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_ov <= 1'b0;
               r_z  <= 1'b0;
            end else if (w_adv) begin
               r_ov <= (w_oa[SW-1] == w_ob[SW-1]) &&
                       (w_sum[SW-1] != w_oa[SW-1]);
               r_z  <= (w_res == '0);
            end
         end
      end
   end

   assign out_valid = g_st[STAGES-1].r_v;
   assign s         = g_st[STAGES-1].r_s;
   assign co        = g_st[STAGES-1].r_c;
   assign ov        = g_st[STAGES-1].g_fl.r_ov;
   assign z         = g_st[STAGES-1].g_fl.r_z;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: default build plus
// 64/8/4 and 16/4/1 configurations.
module tb_cla_addsub_pipe;

   typedef struct {
      logic [66:0] v;
      int          t;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_in = 0;
   int n_out = 0;
   bit lat_chk;

   always @(posedge clk) cyc++;

   logic        in_valid, in_ready, ci, sub;
   logic        out_valid, out_ready, co, ov, z;
   logic [31:0] a, b, s;

   logic        x1_iv, x1_ir, x1_ci, x1_sub, x1_ov_v, x1_co, x1_ovf, x1_z;
   logic [63:0] x1_a, x1_b, x1_s;
   logic        x2_iv, x2_ir, x2_ci, x2_sub, x2_ov_v, x2_co, x2_ovf, x2_z;
   logic [15:0] x2_a, x2_b, x2_s;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   cla_addsub_pipe dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ov(ov), .z(z)
   );

   cla_addsub_pipe #(.WIDTH(64), .GROUP(8), .STAGES(4)) dut64 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(x1_iv), .in_ready(x1_ir),
      .a(x1_a), .b(x1_b), .ci(x1_ci), .sub(x1_sub),
      .out_valid(x1_ov_v), .out_ready(1'b1),
      .s(x1_s), .co(x1_co), .ov(x1_ovf), .z(x1_z)
   );

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(1)) dut16 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(x2_iv), .in_ready(x2_ir),
      .a(x2_a), .b(x2_b), .ci(x2_ci), .sub(x2_sub),
      .out_valid(x2_ov_v), .out_ready(1'b1),
      .s(x2_s), .co(x2_co), .ov(x2_ovf), .z(x2_z)
   );

   function automatic logic [66:0] pk(logic c, logic o, logic zz,
                                      logic [63:0] ss);
      return {c, o, zz, ss};
   endfunction

   // Reference: plain wide addition truncated to w bits.
   function automatic logic [66:0] model(logic [63:0] ma, logic [63:0] mb,
                                         logic mci, logic msub, int w);
      logic [63:0] m, bx, rs;
      logic [64:0] f;
      logic        c, o;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bx = (msub ? ~mb : mb) & m;
      f  = {1'b0, ma & m} + {1'b0, bx} + {64'd0, (msub ? 1'b1 : mci)};
      rs = f[63:0] & m;
      c  = f[w];
      o  = (ma[w-1] == bx[w-1]) && (rs[w-1] != ma[w-1]);
      return {c, o, (rs == 64'd0), rs};
   endfunction

   task automatic check(string tag, logic [66:0] got, logic [66:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Main DUT monitor: pop on output transfer, push on input transfer.
   logic        p_stall = 1'b0;
   logic [66:0] p_out;
   always @(negedge clk) begin : mon0
      exp_t e;
      if (out_valid && out_ready) begin
         if (q0.size() == 0) check("m_spurious", 67'(q0.size()), 67'd1);
         else begin
            e = q0.pop_front();
            check("m_res", pk(co, ov, z, 64'(s)), e.v);
            if (lat_chk) check("m_lat", 67'(cyc - e.t), 67'd2);
            n_out++;
         end
      end
      if (out_valid && !out_ready && p_stall)
         check("m_hold", pk(co, ov, z, 64'(s)), p_out);
      p_stall = out_valid && !out_ready;
      p_out   = pk(co, ov, z, 64'(s));
      if (in_valid && in_ready) begin
         q0.push_back('{model(64'(a), 64'(b), ci, sub, 32), cyc});
         n_in++;
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (x1_ov_v) begin
         if (q1.size() == 0) check("w64_spurious", 67'(q1.size()), 67'd1);
         else begin
            e = q1.pop_front();
            check("w64_res", pk(x1_co, x1_ovf, x1_z, x1_s), e.v);
            check("w64_lat", 67'(cyc - e.t), 67'd4);
         end
      end
      if (x1_iv && x1_ir)
         q1.push_back('{model(x1_a, x1_b, x1_ci, x1_sub, 64), cyc});
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (x2_ov_v) begin
         if (q2.size() == 0) check("w16_spurious", 67'(q2.size()), 67'd1);
         else begin
            e = q2.pop_front();
            check("w16_res", pk(x2_co, x2_ovf, x2_z, 64'(x2_s)), e.v);
            check("w16_lat", 67'(cyc - e.t), 67'd1);
         end
      end
      if (x2_iv && x2_ir)
         q2.push_back('{model(64'(x2_a), 64'(x2_b), x2_ci, x2_sub, 16), cyc});
   end

   // Present one operand set and hold it until accepted.
   task automatic op(input logic [31:0] ia, input logic [31:0] ib,
                     input logic ici, input logic isub);
      int n;
      a = ia; b = ib; ci = ici; sub = isub;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("op_timeout", 67'(in_ready), 67'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic dir(string tag, input logic [31:0] ia,
                      input logic [31:0] ib, input logic ici,
                      input logic isub, input logic [31:0] es,
                      input logic ec, input logic eo, input logic ez);
      int lat;
      op(ia, ib, ici, isub);
      in_valid = 1'b0;
      wait_out(lat);
      check({tag, "_lat"}, 67'(lat), 67'd2);
      check({tag, "_res"}, pk(co, ov, z, 64'(s)), pk(ec, eo, ez, 64'(es)));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 0; a = 0; b = 0; ci = 0; sub = 0; out_ready = 1;
      x1_iv = 0; x1_a = 0; x1_b = 0; x1_ci = 0; x1_sub = 0;
      x2_iv = 0; x2_a = 0; x2_b = 0; x2_ci = 0; x2_sub = 0;
      lat_chk = 1;
      reset_n = 1;
      #1 reset_n = 0;
      #1;
      check("rst_valid", 67'(out_valid), 67'd0);
      check("rst_out", pk(co, ov, z, 64'(s)), 67'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      #1 check("rst_rdy", 67'(in_ready), 67'd1);
      @(posedge clk);
      #1;

      dir("d1", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1, 0, 1);
      dir("d2", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 0, 1, 0);
      dir("d3", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 0, 0, 0);
      dir("d4", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1, 1, 0);
      dir("d5", 32'h1234, 32'h0, 1'b0, 1'b1, 32'h1234, 1, 0, 0);
      dir("d6", 32'h3, 32'h3, 1'b1, 1'b1, 32'h0, 1, 0, 1);
      dir("d7", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h1, 1, 1, 0);

      for (int i = 0; i < 10; i++)
         op($urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      in_valid = 0;
      drain();

      lat_chk = 0;
      out_ready = 0;
      op($urandom, $urandom, 1'b0, 1'b0);
      op($urandom, $urandom, 1'b1, 1'b1);
      a = $urandom; b = $urandom; ci = 1; sub = 0;
      in_valid = 1;
      repeat (3) begin
         @(negedge clk);
         check("bp_rdy", 67'(in_ready), 67'd0);
      end
      @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk);
      #1 in_valid = 0;
      drain();
      check("bp_count", 67'(n_out), 67'(n_in));

      op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
      op(32'h33333333, 32'h44444444, 1'b0, 1'b1);
      in_valid = 0;
      #2 reset_n = 0;
      #1;
      check("mr_valid", 67'(out_valid), 67'd0);
      check("mr_out", pk(co, ov, z, 64'(s)), 67'd0);
      q0.delete();
      @(negedge clk);
      reset_n = 1;
      #1 check("mr_rdy", 67'(in_ready), 67'd1);
      repeat (4) begin
         @(negedge clk);
         check("mr_stale", 67'(out_valid), 67'd0);
      end
      @(posedge clk);
      #1;
      dir("d8", 32'h10, 32'h1, 1'b0, 1'b1, 32'hF, 1, 0, 0);

      for (int i = 0; i < 12; i++) begin
         x1_a = {$urandom, $urandom};
         x1_b = (i == 0) ? 64'd0 : {$urandom, $urandom};
         x1_ci = 1'($urandom_range(0, 1));
         x1_sub = 1'($urandom_range(0, 1));
         x1_iv = 1;
         x2_a = 16'($urandom);
         x2_b = (i == 1) ? ~x2_a : 16'($urandom);
         x2_ci = 1'($urandom_range(0, 1));
         x2_sub = (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         x2_iv = 1;
         @(posedge clk);
         #1;
      end
      x1_iv = 0;
      x2_iv = 0;
      drain();

      check("q0_empty", 67'(q0.size()), 67'd0);
      check("q1_empty", 67'(q1.size()), 67'd0);
      check("q2_empty", 67'(q2.size()), 67'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
